// File: rtl/fpu_add_arbiter.sv
// Round-robin arbiter that shares a single stb/ack fpu_adder among NUM_REQ
// requesters. One operation is in flight at a time. The granted operand pair
// is captured and presented to the adder, the sum is collected, and the sum
// is returned to the owner on rsp_z with a one-hot rsp_valid.
module fpu_add_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_z,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [IDX_W-1:0]         grant_idx,
  output logic                     fpu_rst,
  output logic [WIDTH-1:0]         fpu_a,
  output logic [WIDTH-1:0]         fpu_b,
  output logic                     fpu_a_stb,
  output logic                     fpu_b_stb,
  input  logic                     fpu_a_ack,
  input  logic                     fpu_b_ack,
  input  logic [WIDTH-1:0]         fpu_z,
  input  logic                     fpu_z_stb,
  output logic                     fpu_z_ack
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_Z, RESP} state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             a_done;      // operand A accepted by the adder
  logic             b_done;      // operand B accepted by the adder

  // The adder is held in reset whenever this block is.
  assign fpu_rst = ~rst;

  // Round-robin search: first valid requester starting one past last_grant.
  // NOTE: every variable written in an always_comb gets a default at the top,
  // so no path through the block can leave it unassigned and infer a latch.
  always_comb begin : rr_search
    logic [IDX_W-1:0] cand;
    pick_idx   = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_idx   = cand;
        pick_found = 1'b1;
      end
    end
  end

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic for the grant / load / wait / respond sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_found) state_next = LOAD;
      LOAD:    if ((a_done || fpu_a_ack) && (b_done || fpu_b_ack)) state_next = WAIT_Z;
      WAIT_Z:  if (fpu_z_stb) state_next = RESP;
      RESP:    if (rsp_ready[grant_idx]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture on grant, handshake tracking, result capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant <= IDX_W'(NUM_REQ - 1);
      grant_idx  <= '0;
      fpu_a      <= '0;
      fpu_b      <= '0;
      rsp_z      <= '0;
      a_done     <= 1'b0;
      b_done     <= 1'b0;
    end else begin
      if (state == IDLE && pick_found) begin
        fpu_a      <= req_a[int'(pick_idx)*WIDTH +: WIDTH];
        fpu_b      <= req_b[int'(pick_idx)*WIDTH +: WIDTH];
        grant_idx  <= pick_idx;
        last_grant <= pick_idx;
        a_done     <= 1'b0;
        b_done     <= 1'b0;
      end
      if (fpu_a_stb && fpu_a_ack) a_done <= 1'b1;
      if (fpu_b_stb && fpu_b_ack) b_done <= 1'b1;
      if (fpu_z_stb && fpu_z_ack) rsp_z <= fpu_z;
    end
  end

  // Handshake outputs decoded from state; all forced low while in reset so a
  // reset cycle can never complete a transfer on either side.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    fpu_a_stb = 1'b0;
    fpu_b_stb = 1'b0;
    fpu_z_ack = 1'b0;
    if (rst) begin
      case (state)
        IDLE:    if (pick_found) req_ready[pick_idx] = 1'b1;
        LOAD: begin
          fpu_a_stb = ~a_done;
          fpu_b_stb = ~b_done;
        end
        WAIT_Z:  fpu_z_ack = fpu_z_stb;
        RESP:    rsp_valid[grant_idx] = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Bench for fpu_add_arbiter: a behavioural stb/ack adder model with random
// handshake delays sits on the adder side; directed scenarios and a random
// scoreboard run check the requester side.
`timescale 1ns/1ps
module tb_fpu_add_arbiter;

  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_z;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [IDX_W-1:0]         grant_idx;
  logic                     fpu_rst;
  logic [WIDTH-1:0]         fpu_a;
  logic [WIDTH-1:0]         fpu_b;
  logic                     fpu_a_stb;
  logic                     fpu_b_stb;
  logic                     fpu_a_ack;
  logic                     fpu_b_ack;
  logic [WIDTH-1:0]         fpu_z;
  logic                     fpu_z_stb;
  logic                     fpu_z_ack;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_add_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_z(rsp_z), .rsp_ready(rsp_ready), .grant_idx(grant_idx),
    .fpu_rst(fpu_rst), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_a_stb(fpu_a_stb), .fpu_b_stb(fpu_b_stb),
    .fpu_a_ack(fpu_a_ack), .fpu_b_ack(fpu_b_ack),
    .fpu_z(fpu_z), .fpu_z_stb(fpu_z_stb), .fpu_z_ack(fpu_z_ack)
  );

  // ---------------- float helpers (normal numbers only) ----------------
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] rand_float();
    return {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
  endfunction

  // Round-robin reference: first valid index after the previous winner.
  function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] v);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // ---------------- adder model: takes A, then B, computes, offers Z ----------------
  typedef enum {M_GET_A, M_GET_B, M_BUSY, M_PUT_Z} mphase_t;
  mphase_t     mph;
  int          mwait;
  logic [31:0] ma, mb;

  initial begin
    fpu_a_ack = 1'b0; fpu_b_ack = 1'b0; fpu_z_stb = 1'b0; fpu_z = '0;
    mph = M_GET_A; mwait = 0; ma = '0; mb = '0;
    forever begin
      @(negedge clk); #1;
      fpu_a_ack = 1'b0; fpu_b_ack = 1'b0; fpu_z_stb = 1'b0;
      if (fpu_rst) begin
        mph = M_GET_A; mwait = $urandom_range(0, 2);
      end else begin
        case (mph)
          M_GET_A: if (mwait > 0) mwait--; else begin
            fpu_a_ack = 1'b1;
            if (fpu_a_stb) begin ma = fpu_a; mph = M_GET_B; mwait = $urandom_range(0, 2); end
          end
          M_GET_B: if (mwait > 0) mwait--; else begin
            fpu_b_ack = 1'b1;
            if (fpu_b_stb) begin mb = fpu_b; mph = M_BUSY; mwait = $urandom_range(1, 5); end
          end
          M_BUSY: if (mwait > 0) mwait--; else mph = M_PUT_Z;
          M_PUT_Z: begin
            fpu_z = fadd(ma, mb); fpu_z_stb = 1'b1;
            #1;
            if (fpu_z_ack) begin mph = M_GET_A; mwait = $urandom_range(0, 2); end
          end
          default: mph = M_GET_A;
        endcase
      end
    end
  end

  // ---------------- stimulus helpers (no comparisons inside) ----------------
  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_valid[i] = 1'b1;
  endtask

  // Called at a falling edge with inputs already driven; returns at +3 of the
  // first cycle showing req_ready (or 0 after the budget runs out).
  task automatic wait_ready(output logic [NUM_REQ-1:0] seen, input int limit);
    int c = 0;
    #3;
    while (req_ready == '0 && c < limit) begin
      @(negedge clk); #3; c++;
    end
    seen = req_ready;
  endtask

  task automatic wait_rsp(output logic [NUM_REQ-1:0] seen, input int limit);
    int c = 0;
    #3;
    while (rsp_valid == '0 && c < limit) begin
      @(negedge clk); #3; c++;
    end
    seen = rsp_valid;
  endtask

  // Pulse rsp_ready for requester k; returns at a falling edge.
  task automatic accept_rsp(input int k);
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready = '0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0; rsp_ready = '0;
    repeat (n) @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0; req_valid = 4'b1111; req_a = '0; req_b = '0; rsp_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #3;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
    checks++; if (rsp_z !== 32'd0 || fpu_a !== 32'd0 || fpu_b !== 32'd0) begin errors++; $display("FAIL reset_data: rsp_z %h fpu_a %h fpu_b %h expected all 0", rsp_z, fpu_a, fpu_b); end
    checks++; if ({fpu_a_stb, fpu_b_stb, fpu_z_ack} !== 3'b000) begin errors++; $display("FAIL reset_handshake: got %b expected 000", {fpu_a_stb, fpu_b_stb, fpu_z_ack}); end
    checks++; if (fpu_rst !== 1'b1) begin errors++; $display("FAIL reset_fpu_rst: got %b expected 1", fpu_rst); end
    checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL reset_grant_idx: got %0d expected 0", grant_idx); end
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    #3;
    checks++; if (fpu_rst !== 1'b0) begin errors++; $display("FAIL release_fpu_rst: got %b expected 0", fpu_rst); end
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [NUM_REQ-1:0] seen;
    set_req(0, 32'h3F800000, 32'h40000000);
    wait_ready(seen, 20);
    checks++; if (seen !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", seen); end
    @(negedge clk); #3;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL single_ready_pulse: got %b expected 0000", req_ready); end
    checks++; if (fpu_a !== 32'h3F800000 || fpu_b !== 32'h40000000) begin errors++; $display("FAIL single_operands: got %h %h expected 3f800000 40000000", fpu_a, fpu_b); end
    req_valid = '0;
    @(negedge clk);
    wait_rsp(seen, 200);
    checks++; if (seen !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid: got %b expected 0001", seen); end
    checks++; if (rsp_z !== 32'h40400000) begin errors++; $display("FAIL single_rsp_z: got %h expected 40400000", rsp_z); end
    accept_rsp(0);
  endtask

  task automatic test_all_four();
    logic [NUM_REQ-1:0] seen;
    logic [NUM_REQ-1:0] exp_mask;
    do_reset(2);
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'h3F000000, 32'h3E800000);
    for (int k = 0; k < NUM_REQ; k++) begin
      exp_mask = 4'b0001 << k;
      wait_ready(seen, 50);
      checks++; if (seen !== exp_mask) begin errors++; $display("FAIL all4_grant%0d: got %b expected %b", k, seen, exp_mask); end
      @(negedge clk);
      req_valid[k] = 1'b0;
      wait_rsp(seen, 200);
      checks++; if (seen !== exp_mask || rsp_z !== 32'h3F400000 || grant_idx !== 2'(k)) begin
        errors++; $display("FAIL all4_rsp%0d: valid %b z %h idx %0d expected %b 3f400000 %0d", k, seen, rsp_z, grant_idx, exp_mask, k);
      end
      accept_rsp(k);
    end
  endtask

  task automatic test_wrap_priority();
    logic [NUM_REQ-1:0] seen;
    set_req(0, 32'h40000000, 32'h3F800000);
    set_req(1, 32'h3F800000, 32'h3F800000);
    wait_ready(seen, 50);
    checks++; if (seen !== 4'b0001) begin errors++; $display("FAIL wrap_first: got %b expected 0001", seen); end
    @(negedge clk); req_valid[0] = 1'b0;
    wait_rsp(seen, 200);
    checks++; if (seen !== 4'b0001 || rsp_z !== 32'h40400000) begin errors++; $display("FAIL wrap_rsp0: valid %b z %h expected 0001 40400000", seen, rsp_z); end
    accept_rsp(0);
    wait_ready(seen, 50);
    checks++; if (seen !== 4'b0010) begin errors++; $display("FAIL wrap_second: got %b expected 0010", seen); end
    @(negedge clk); req_valid[1] = 1'b0;
    wait_rsp(seen, 200);
    checks++; if (seen !== 4'b0010 || rsp_z !== 32'h40000000) begin errors++; $display("FAIL wrap_rsp1: valid %b z %h expected 0010 40000000", seen, rsp_z); end
    accept_rsp(1);
  endtask

  task automatic test_backpressure();
    logic [NUM_REQ-1:0] seen;
    set_req(2, 32'h40000000, 32'h40400000);
    wait_ready(seen, 50);
    checks++; if (seen !== 4'b0100) begin errors++; $display("FAIL hold_grant: got %b expected 0100", seen); end
    @(negedge clk); req_valid[2] = 1'b0;
    wait_rsp(seen, 200);
    set_req(0, 32'h3F800000, 32'h3F800000);
    rsp_ready = 4'b1011;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #3;
      checks++; if (rsp_valid !== 4'b0100 || rsp_z !== 32'h40A00000 || req_ready !== 4'b0) begin
        errors++; $display("FAIL hold_cycle%0d: valid %b z %h ready %b expected 0100 40a00000 0000", c, rsp_valid, rsp_z, req_ready);
      end
    end
    rsp_ready = '0;
    accept_rsp(2);
    wait_ready(seen, 50);
    checks++; if (seen !== 4'b0001) begin errors++; $display("FAIL hold_next_grant: got %b expected 0001", seen); end
    @(negedge clk); req_valid[0] = 1'b0;
    wait_rsp(seen, 200);
    checks++; if (seen !== 4'b0001 || rsp_z !== 32'h40000000) begin errors++; $display("FAIL hold_next_rsp: valid %b z %h expected 0001 40000000", seen, rsp_z); end
    accept_rsp(0);
  endtask

  task automatic test_mid_reset();
    logic [NUM_REQ-1:0] seen;
    int c;
    set_req(1, 32'h3F800000, 32'h40000000);
    wait_ready(seen, 50);
    checks++; if (seen !== 4'b0010) begin errors++; $display("FAIL midrst_grant: got %b expected 0010", seen); end
    @(negedge clk); req_valid[1] = 1'b0;
    c = 0;
    #3;
    while ((fpu_a_stb || fpu_b_stb) && c < 50) begin @(negedge clk); #3; c++; end
    checks++; if (fpu_a_stb || fpu_b_stb || rsp_valid !== 4'b0) begin
      errors++; $display("FAIL midrst_reach_wait: stb %b%b valid %b expected 00 0000", fpu_a_stb, fpu_b_stb, rsp_valid);
    end
    rst = 1'b0;
    @(negedge clk); #3;
    rst = 1'b1;
    checks++; if (rsp_valid !== 4'b0 || grant_idx !== 2'd0 || fpu_a !== 32'd0) begin
      errors++; $display("FAIL midrst_state: valid %b idx %0d fpu_a %h expected 0000 0 0", rsp_valid, grant_idx, fpu_a);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #3;
      checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL midrst_no_rsp%0d: got %b expected 0000", k, rsp_valid); end
    end
    @(negedge clk);
    set_req(2, 32'h3F800000, 32'h3F800000);
    wait_ready(seen, 50);
    checks++; if (seen !== 4'b0100) begin errors++; $display("FAIL midrst_new_grant: got %b expected 0100", seen); end
    @(negedge clk); req_valid[2] = 1'b0;
    wait_rsp(seen, 200);
    checks++; if (seen !== 4'b0100 || rsp_z !== 32'h40000000) begin errors++; $display("FAIL midrst_new_rsp: valid %b z %h expected 0100 40000000", seen, rsp_z); end
    accept_rsp(2);
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] exp_ready;
    logic [NUM_REQ-1:0] owner_mask;
    logic [31:0]        exp_z;
    int last = NUM_REQ - 1;
    int owner = 0;
    int busy = 0;
    int busy_cycles = 0;
    int drop_next = -1;
    int served = 0;
    int g;
    do_reset(2);
    owner_mask = '0; exp_z = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (drop_next >= 0) begin req_valid[drop_next] = 1'b0; drop_next = -1; end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) set_req(i, rand_float(), rand_float());
        end else if ($urandom_range(0, 31) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = 4'($urandom);
      #3;
      exp_ready = '0;
      g = -1;
      if (busy == 0 && req_valid != '0) begin
        g = rr_pick(last, req_valid);
        exp_ready[g] = 1'b1;
      end
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rand_ready cyc%0d: got %b expected %b", cyc, req_ready, exp_ready); end
      if (rsp_valid !== 4'b0) begin
        checks++;
        if (busy == 0 || rsp_valid !== owner_mask || rsp_z !== exp_z) begin
          errors++; $display("FAIL rand_rsp cyc%0d: valid %b z %h expected %b %h (busy %0d)", cyc, rsp_valid, rsp_z, owner_mask, exp_z, busy);
        end else if (rsp_ready[owner]) begin
          busy = 0; served++;
        end
      end
      if (g >= 0) begin
        owner = g; owner_mask = exp_ready; last = g;
        exp_z = fadd(req_a[g*WIDTH +: WIDTH], req_b[g*WIDTH +: WIDTH]);
        busy = 1; busy_cycles = 0; drop_next = g;
      end else if (busy != 0) begin
        busy_cycles++;
        if (busy_cycles > 200) begin
          checks++; errors++;
          $display("FAIL rand_timeout cyc%0d: no response for owner %0d within 200 cycles", cyc, owner);
          break;
        end
      end
    end
    checks++; if (served < 50) begin errors++; $display("FAIL rand_throughput: served %0d expected at least 50", served); end
    @(negedge clk);
    req_valid = '0; rsp_ready = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_wrap_priority();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
